// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for ahb_lite_sram_slave.
// Ports: master drives HSEL/HADDR/HWRITE/HTRANS/HSIZE/HWDATA/HREADY,
//        slave drives HRDATA/HREADYOUT/HRESP.
interface ahb_lite_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite word-addressed SRAM slave with programmable wait states,
// byte/halfword/word writes and zero-wait read-after-write forwarding.
// Ports: HCLK, HRESETn (async active-low), ahb (slave modport of
//        ahb_lite_sram_slave_if: address/control/HWDATA in, HRDATA,
//        HREADYOUT, HRESP out).
// Optional: define AHB_SLV_ERR_RESP_EN for a two-cycle ERROR response on
//        accesses with any of HADDR[31:ADDR_W+2] set; otherwise the upper
//        address bits alias and HRESP is tied to OKAY.
module ahb_lite_sram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_lite_sram_slave_if.slave ahb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam int         DEPTH        = 1 << ADDR_W;
    localparam bit         LP_HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] LP_WAIT_LOAD =
        LP_HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_lane;
    logic                r_write;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [DEPTH];

    logic                w_accept;
    logic                w_oor;
    logic [ADDR_W-1:0]   w_addr;
    logic [3:0]          w_lane;
    logic                w_commit;
    logic [31:0]         w_wmask;
    logic                w_rd_now;
    logic                w_rd_late;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [31:0]         w_rd_word;
    logic                w_hit;
    logic [31:0]         w_fwd_word;
    logic                w_hreadyout;
    logic                w_hresp;
    logic                w_unused;

    assign w_accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign w_addr   = ahb.HADDR[ADDR_W+1:2];

`ifdef AHB_SLV_ERR_RESP_EN
    assign w_oor    = |ahb.HADDR[31:ADDR_W+2];
    assign w_unused = ahb.HTRANS[0];
    assign ahb.HRESP = w_hresp;
`else
    assign w_oor    = 1'b0;
    assign w_unused = ^{ahb.HTRANS[0], ahb.HADDR[31:ADDR_W+2], w_hresp};
    assign ahb.HRESP = 1'b0;
`endif

    // Byte-enable mask for the address phase currently on the bus.
    always_comb begin
        w_lane = 4'b1111;
        unique case (ahb.HSIZE)
            3'd0:    w_lane = 4'b0001 << ahb.HADDR[1:0];
            3'd1:    w_lane = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_lane = 4'b1111;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_wmask[8*i +: 8] = {8{r_lane[i]}};
        end
    end

    // Writes commit at the closing edge of the single DATA cycle.
    assign w_commit = (r_state == S_DATA) && r_write;

    // Zero-wait reads sample memory at their accept edge; waited reads
    // sample at the edge leaving the last WAIT cycle.
    assign w_rd_now  = w_accept & ~ahb.HWRITE & ~w_oor & ~LP_HAS_WAIT;
    assign w_rd_late = (r_state == S_WAIT) && (r_cnt == 4'd0) && !r_write;
    assign w_rd_addr = w_rd_late ? r_addr : w_addr;
    assign w_rd_word = r_mem[w_rd_addr];

    // A read landing on the word being written this same edge sees the
    // new lanes from HWDATA and the old lanes from memory.
    assign w_hit      = w_commit && (r_addr == w_rd_addr);
    assign w_fwd_word = w_hit
        ? ((w_rd_word & ~w_wmask) | (ahb.HWDATA & w_wmask))
        : w_rd_word;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hreadyout = 1'b1;
        w_hresp     = 1'b0;
        unique case (r_state)
            S_WAIT: begin
                w_hreadyout = 1'b0;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = 1'b1;
                w_state_nxt = S_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all complete a cycle with HREADYOUT=1
                // and may take the next address phase.
                if (r_state == S_ERR2) begin
                    w_hresp = 1'b1;
                end
                if (w_accept && w_oor) begin
                    w_state_nxt = S_ERR1;
                end else if (w_accept && LP_HAS_WAIT) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = LP_WAIT_LOAD;
                end else if (w_accept) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_lane  <= 4'd0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= w_addr;
            r_lane  <= w_lane;
            r_write <= ahb.HWRITE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rdata <= 32'd0;
        end else if (w_rd_now || w_rd_late) begin
            r_rdata <= w_fwd_word;
        end
    end

    // Storage is not reset; per-byte enables keep it RAM-mappable.
    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_lane[i]) begin
                    r_mem[r_addr][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign ahb.HRDATA    = r_rdata;
    assign ahb.HREADYOUT = w_hreadyout;

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- Word-addressed AHB-Lite "Junior" memory slave sitting directly downstream of the bus master on the shared HCLK/HRESETn bus.
- Decodes address phases, inserts a programmable number of wait states, performs byte/halfword/word writes, and returns read data on HRDATA with HREADYOUT/HRESP.
- Serves as the target memory model for master bring-up and as the first real slave in the fabric.

Parameters:
- ADDR_W, 10, word-address width; memory holds 2**ADDR_W 32-bit words and decodes HADDR[ADDR_W+1:2].
- WAIT_CYCLES, 0, wait states inserted per transfer (0..15); 0 gives zero-wait OKAY responses.

Ports:
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESETn  in  1  reset, asynchronous assert, active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  address (address phase).
- HWRITE  in  1  1=write, 0=read (address phase).
- HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is an active transfer; IDLE/BUSY are ignored.
- HSIZE  in  3  0=byte, 1=halfword, 2=word; other values are treated as word.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-wide ready (previous transfer done).
- HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase.
- HREADYOUT  out  1  slave ready; 0 extends the data phase.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (async, HRESETn=0): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, pending-write registers cleared. Memory contents are not reset.
- Accept condition: HSEL & HREADY & HTRANS[1] at a rising edge. On accept, the slave latches addr_q=HADDR[ADDR_W+1:2], lane_q (byte-enable mask from HSIZE and HADDR[1:0]) and write_q=HWRITE.
- Byte enables:
  - byte: lane HADDR[1:0].
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1}; HADDR[0] is ignored.
  - word: all 4 lanes; HADDR[1:0] is ignored.
- FSM states and transitions:
  - IDLE: no transfer pending; HREADYOUT=1. On accept, go to WAIT if WAIT_CYCLES>0, otherwise go to DATA.
  - WAIT: HREADYOUT=0. The counter loads WAIT_CYCLES-1 on entry and decrements each cycle; at 0, go to DATA.
  - DATA: HREADYOUT=1 (last data-phase cycle). HWDATA is sampled at the closing edge, and the write commits to memory with lane masking. On a new accept in this same cycle (back-to-back), go to WAIT or DATA; otherwise go to IDLE.
- Latency: a transfer occupies exactly WAIT_CYCLES+1 data-phase cycles. The address-to-data pipeline is 1 cycle, as per AHB.
- Read data:
  - Memory is read at the edge that enters the final data-phase cycle, into the HRDATA register.
  - HRDATA holds its last value outside read data phases.
- Read-after-write hazard (zero-wait only): a read accepted in the same cycle that a write to the same word commits must return the merged data. Lanes being written take the new HWDATA; other lanes take the old memory contents. No stale data is allowed.
- A write data phase leaves HRDATA unchanged.
- HSEL=0 or HTRANS IDLE/BUSY while HREADY=1: no state change; OKAY, HREADYOUT=1.
- Reset mid-transfer: the FSM returns to IDLE immediately, and a write that has not yet reached its closing edge is dropped.

Optional Feature:
- Macro: AHB_SLV_ERR_RESP_EN.
- Enabled, out-of-range access (any of HADDR[31:ADDR_W+2] nonzero at accept):
  - No memory access is performed.
  - Two-cycle ERROR response: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1; then IDLE or next accept.
  - Wait states are not inserted for errored transfers.
- Disabled: upper address bits are ignored (the memory aliases) and HRESP is constant 0.

Test Plan:
- Reset: HRESETn=0 asserted asynchronously mid-cycle -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately, without waiting for a clock edge.
- Zero-wait: WAIT_CYCLES=0, write word 0xCAFEF00D to 0x10, then read 0x10 back-to-back -> read data phase HRDATA=0xCAFEF00D (bypass path), HREADYOUT never 0.
- Byte lanes: word write 0x11223344 to 0x20; byte write 0xAA to 0x21 (HSIZE=0); halfword write 0xBEEF to 0x22 (HSIZE=1); read 0x20 -> 0xBEEFAA44.
- Wait states: WAIT_CYCLES=3, read 0x04 preloaded with 0x5A5A5A5A -> HREADYOUT low exactly 3 cycles, then high with HRDATA=0x5A5A5A5A.
- Idle/unselected: HTRANS=IDLE with HWRITE=1, then HSEL=0 with HTRANS=NONSEQ and HWRITE=1 -> memory unchanged, HREADYOUT=1, HRESP=0.
- Error (macro on, ADDR_W=10): read 0x00001000 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, memory word 0 untouched. Macro off: the same access aliases to word 0.
